vend_payout: RTL and testbench

- Dispense-side controller that sits downstream of the vending machine controller.
- Receives the one-cycle change/sell result pulse and turns it into handshaked actuator requests:
  - product eject first;
  - then 5-yuan coins, greedy;
  - then 1-yuan coins.
- Handles empty hoppers, actuator timeouts and requests that arrive while a payout is in progress.

---
 rtl/vend_payout.sv | 181 ++++++++++++++++++
 tb/tb_vend_payout.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/vend_payout.sv
// Dispense-side payout sequencer: ejects the product, then pays change as greedy
// 5-yuan coins followed by 1-yuan coins over handshaked actuator requests.
module vend_payout #(
    parameter int unsigned GAP_CYC     = 4,
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] change_i,
    input  logic [2:0] sell_i,
    input  logic       hop5_empty,
    input  logic       hop1_empty,
    output logic [2:0] vend_req,
    input  logic       vend_ack,
    output logic       coin5_req,
    output logic       coin1_req,
    input  logic       coin_ack,
    output logic       busy,
    output logic       done,
    output logic       req_drop,
    output logic       fault,
    output logic [3:0] owed
);

    localparam int unsigned REM_W  = 4;
    localparam int unsigned PROD_W = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_VEND  = 3'd1,
        S_GAP   = 3'd2,
        S_SEL   = 3'd3,
        S_PAY5  = 3'd4,
        S_PAY1  = 3'd5,
        S_DONE  = 3'd6,
        S_FAULT = 3'd7
    } state_e;

    state_e              state_q, state_d;
    logic [REM_W-1:0]    rem_q, rem_d;
    logic [PROD_W-1:0]   prod_q, prod_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    cnt_inc;
    logic                new_req;

    logic [PROD_W-1:0]   vend_req_q, vend_req_d;
    logic                coin5_req_q, coin5_req_d;
    logic                coin1_req_q, coin1_req_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                req_drop_q, req_drop_d;
    logic                fault_q, fault_d;
    logic [REM_W-1:0]    owed_q, owed_d;

    // Next-state, working registers and registered output values
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + CNT_W'(1);
        new_req = (change_i != '0) || (sell_i != '0);

        case (state_q)
            S_IDLE: begin
                if (new_req) begin
                    rem_d   = change_i;
                    prod_d  = sell_i;
                    cnt_d   = '0;
                    state_d = (sell_i != '0) ? S_VEND : S_SEL;
                end
            end
            S_VEND: begin
                if (vend_ack) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else if (cnt_inc == CNT_W'(ACK_TIMEOUT)) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_GAP: begin
                if (cnt_inc == CNT_W'(GAP_CYC)) begin
                    cnt_d   = '0;
                    state_d = S_SEL;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_SEL: begin
                // An empty 5-yuan hopper falls through to 1-yuan coins
                cnt_d = '0;
                if (rem_q == '0) begin
                    state_d = S_DONE;
                end else if ((rem_q >= REM_W'(5)) && !hop5_empty) begin
                    state_d = S_PAY5;
                end else if (!hop1_empty) begin
                    state_d = S_PAY1;
                end else begin
                    state_d = S_FAULT;
                end
            end
            S_PAY5: begin
                if (coin_ack) begin
                    rem_d   = rem_q - REM_W'(5);
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else if (cnt_inc == CNT_W'(ACK_TIMEOUT)) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_PAY1: begin
                if (coin_ack) begin
                    rem_d   = rem_q - REM_W'(1);
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else if (cnt_inc == CNT_W'(ACK_TIMEOUT)) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase

        vend_req_d  = (state_d == S_VEND) ? prod_d : '0;
        coin5_req_d = (state_d == S_PAY5);
        coin1_req_d = (state_d == S_PAY1);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        fault_d     = (state_d == S_FAULT);
        owed_d      = (state_d == S_FAULT) ? rem_d : '0;
        req_drop_d  = (state_q != S_IDLE) && new_req;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
            vend_req_q  <= '0;
            coin5_req_q <= 1'b0;
            coin1_req_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            req_drop_q  <= 1'b0;
            fault_q     <= 1'b0;
            owed_q      <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            prod_q      <= prod_d;
            cnt_q       <= cnt_d;
            vend_req_q  <= vend_req_d;
            coin5_req_q <= coin5_req_d;
            coin1_req_q <= coin1_req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            req_drop_q  <= req_drop_d;
            fault_q     <= fault_d;
            owed_q      <= owed_d;
        end
    end

    assign vend_req  = vend_req_q;
    assign coin5_req = coin5_req_q;
    assign coin1_req = coin1_req_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign req_drop  = req_drop_q;
    assign fault     = fault_q;
    assign owed      = owed_q;

endmodule

// File: tb/tb_vend_payout.sv
// Bench for vend_payout: an event-timeline reference model predicts every output
// cycle by cycle for directed and randomized payouts.
module tb_vend_payout;

    localparam int GAP = 4;
    localparam int AT  = 255;
    localparam int NC  = 1024;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] change_i;
    logic [2:0] sell_i;
    logic       hop5_empty, hop1_empty;
    logic [2:0] vend_req;
    logic       vend_ack;
    logic       coin5_req, coin1_req;
    logic       coin_ack;
    logic       busy, done, req_drop, fault;
    logic [3:0] owed;

    always #5 clk = ~clk;

    vend_payout #(.GAP_CYC(GAP), .ACK_TIMEOUT(AT), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .change_i(change_i), .sell_i(sell_i),
        .hop5_empty(hop5_empty), .hop1_empty(hop1_empty),
        .vend_req(vend_req), .vend_ack(vend_ack),
        .coin5_req(coin5_req), .coin1_req(coin1_req), .coin_ack(coin_ack),
        .busy(busy), .done(done), .req_drop(req_drop), .fault(fault), .owed(owed)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // expected outputs and stimulus per cycle, relative to the trigger cycle 0
    logic [2:0] e_vreq [NC];
    logic       e_c5 [NC], e_c1 [NC], e_busy [NC], e_done [NC];
    logic       e_drop [NC], e_fault [NC];
    logic [3:0] e_owed [NC];
    logic       a_v [NC], a_c [NC];
    logic [3:0] inj_c [NC];
    logic [2:0] inj_s [NC];
    int         dly [32];
    logic [12:0] obs, ex;

    function automatic logic [12:0] outs_now();
        return {vend_req, coin5_req, coin1_req, busy, done, req_drop, fault, owed};
    endfunction

    // Timeline model: each request is held (delay+1) cycles, followed by GAP idle
    // cycles plus one decision cycle before the next request or the ending.
    task automatic build(input int c, input int s, input bit h5e, input bit h1e,
                         input bit rnd, output int hor, output bit faulted);
        int rem, sel, rise, d, idx, endc, k, lim;
        bit fin;
        for (int i = 0; i < NC; i++) begin
            e_vreq[i] = '0; e_c5[i] = 0; e_c1[i] = 0; e_busy[i] = 0; e_done[i] = 0;
            e_drop[i] = 0; e_fault[i] = 0; e_owed[i] = '0;
            a_v[i] = 0; a_c[i] = 0; inj_c[i] = '0; inj_s[i] = '0;
        end
        rem = c; idx = 0; fin = 0; faulted = 0; endc = 0; sel = 1;
        if (s != 0) begin
            rise = 1; d = dly[0]; idx = 1;
            for (int j = 0; j <= d && j < AT; j++) e_vreq[rise + j] = 3'(s);
            if (d >= AT) begin
                endc = rise + AT; faulted = 1; fin = 1;
            end else begin
                a_v[rise + d] = 1;
                sel = rise + d + 1 + GAP;
            end
        end
        while (!fin) begin
            if (rem == 0) begin
                endc = sel + 1; e_done[endc] = 1; fin = 1;
            end else begin
                if (rem >= 5 && !h5e) k = 5;
                else if (!h1e) k = 1;
                else k = 0;
                if (k == 0) begin
                    endc = sel + 1; faulted = 1; fin = 1;
                end else begin
                    rise = sel + 1; d = dly[idx]; idx++;
                    for (int j = 0; j <= d && j < AT; j++) begin
                        if (k == 5) e_c5[rise + j] = 1;
                        else        e_c1[rise + j] = 1;
                    end
                    if (d >= AT) begin
                        endc = rise + AT; faulted = 1; fin = 1;
                    end else begin
                        a_c[rise + d] = 1;
                        rem -= k;
                        sel = rise + d + 1 + GAP;
                    end
                end
            end
        end
        hor = faulted ? endc + 6 : endc + 2;
        for (int i = 1; i <= hor; i++) begin
            if (i <= endc || faulted) e_busy[i] = 1;
            if (faulted && i >= endc) begin
                e_fault[i] = 1; e_owed[i] = 4'(rem);
            end
        end
        if (rnd) begin
            for (int i = 0; i <= hor; i++) begin
                if (e_vreq[i] == '0 && $urandom_range(3) == 0) a_v[i] = 1;
                if (!e_c5[i] && !e_c1[i] && $urandom_range(3) == 0) a_c[i] = 1;
            end
            lim = faulted ? hor - 1 : endc;
            for (int i = 1; i <= lim; i++) begin
                if ($urandom_range(5) == 0) begin
                    inj_c[i] = 4'($urandom_range(15));
                    inj_s[i] = 3'($urandom_range(7));
                    if (inj_c[i] == '0 && inj_s[i] == '0) inj_s[i] = 3'd1;
                    e_drop[i + 1] = 1;
                end
            end
        end
    endtask

    task automatic run_case(input string tag, input int tc, input int ts,
                            input int last, output bit bad);
        bad = 0;
        for (int k = 0; k <= last; k++) begin
            @(posedge clk); #1;
            obs = outs_now();
            ex  = {e_vreq[k], e_c5[k], e_c1[k], e_busy[k], e_done[k], e_drop[k], e_fault[k], e_owed[k]};
            n_cmp++;
            assert (obs === ex) else begin
                n_fail++; bad = 1;
                $error("FAIL %s cyc=%0d got=%h exp=%h (vreq,c5,c1,busy,done,drop,fault,owed)", tag, k, obs, ex);
            end
            if (bad) break;
            change_i = (k == 0) ? 4'(tc) : inj_c[k];
            sell_i   = (k == 0) ? 3'(ts) : inj_s[k];
            vend_ack = a_v[k];
            coin_ack = a_c[k];
        end
        change_i = '0; sell_i = '0; vend_ack = 0; coin_ack = 0;
    endtask

    // Asserts rst mid-cycle and requires every output to clear with no clock edge
    task automatic do_reset(input string tag);
        @(posedge clk); #3;
        rst = 1; #1;
        obs = outs_now();
        n_cmp++;
        assert (obs === 13'd0) else begin
            n_fail++;
            $error("FAIL %s_async_rst got=%h exp=%h", tag, obs, 13'd0);
        end
        change_i = '0; sell_i = '0; vend_ack = 0; coin_ack = 0;
        @(negedge clk); @(negedge clk);
        rst = 0;
    endtask

    task automatic full_case(input string tag, input int c, input int s,
                             input bit h5e, input bit h1e, input bit rnd);
        int hor;
        bit flt, bad;
        build(c, s, h5e, h1e, rnd, hor, flt);
        hop5_empty = h5e; hop1_empty = h1e;
        run_case(tag, c, s, hor, bad);
        if (flt || bad) do_reset(tag);
    endtask

    task automatic set_dly(input int v);
        for (int i = 0; i < 32; i++) dly[i] = v;
    endtask

    initial begin
        int c, s, hor;
        bit flt, bad, h5e, h1e;
        rst = 1; change_i = '0; sell_i = '0; hop5_empty = 0; hop1_empty = 0;
        vend_ack = 0; coin_ack = 0;
        #7;
        obs = outs_now();
        n_cmp++;
        assert (obs === 13'd0) else begin
            n_fail++; $error("FAIL reset got=%h exp=%h", obs, 13'd0);
        end
        @(negedge clk); rst = 0;

        set_dly(1); dly[0] = 3;
        full_case("sell_only", 0, 2, 0, 0, 0);
        set_dly(1);
        full_case("change7", 7, 0, 0, 0, 0);
        full_case("hop5_empty", 5, 0, 1, 0, 0);
        full_case("hop1_empty", 3, 0, 0, 1, 0);
        set_dly(1); dly[0] = AT;
        full_case("coin_timeout", 4, 0, 0, 0, 0);
        full_case("vend_timeout", 9, 5, 0, 0, 0);
        set_dly(2); dly[0] = AT - 1;
        full_case("ack_at_limit", 4, 0, 0, 0, 0);

        // request dropped during PAY1, then reset while coin1_req is held
        set_dly(6);
        build(4, 0, 0, 0, 0, hor, flt);
        inj_s[3] = 3'd1; e_drop[4] = 1;
        hop5_empty = 0; hop1_empty = 0;
        run_case("drop_in_pay1", 4, 0, 5, bad);
        do_reset("mid_pay1");

        for (int r = 0; r < 40; r++) begin
            c = $urandom_range(15);
            s = $urandom_range(7);
            if (c == 0 && s == 0) c = 1;
            h5e = ($urandom_range(3) == 0);
            h1e = ($urandom_range(3) == 0);
            for (int i = 0; i < 32; i++) begin
                dly[i] = $urandom_range(4);
                if ($urandom_range(39) == 0) dly[i] = ($urandom_range(1) == 0) ? AT : AT - 1;
            end
            full_case("random", c, s, h5e, h1e, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
